// File: rtl/csr_unit.sv
// Machine-mode CSR file: atomic CSRRW/CSRRS/CSRRC, 64-bit mcycle/minstret counters,
// trap entry/mret sequencing, JTAG debug access and trap target PC generation.
module csr_unit #(
   parameter int unsigned      XLEN        = 32,
   parameter logic [XLEN-1:0]  HART_ID     = '0,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            op_valid,
   input  logic [1:0]      op_type,
   input  logic [11:0]     op_addr,
   input  logic [XLEN-1:0] op_wdata,
   output logic [XLEN-1:0] op_rdata,
   output logic            op_illegal,
   input  logic            retire_i,
   input  logic            trap_i,
   input  logic [XLEN-1:0] trap_cause_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            mret_i,
   input  logic            jtag_we,
   input  logic [11:0]     jtag_addr,
   input  logic [XLEN-1:0] jtag_wdata,
   output logic [XLEN-1:0] jtag_rdata,
   output logic [XLEN-1:0] trap_vec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic [XLEN-1:0] mie_o,
   output logic            gie_o
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   logic            mst_mie;
   logic            mst_mpie;
   logic [XLEN-1:0] mie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [63:0]     mcycle_q;
   logic [63:0]     minstret_q;

   logic            op_writes;
   logic            op_ill;
   logic            op_we;
   logic [XLEN-1:0] op_old;
   logic [XLEN-1:0] op_new;
   logic [XLEN-1:0] tv_base;

   function automatic logic csr_known(input logic [11:0] a);
      case (a)
         A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
         A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH, A_MHARTID: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] csr_read(input logic [11:0] a);
      logic [XLEN-1:0] r;
      r = '0;
      case (a)
         A_MSTATUS: begin
            r[12:11] = 2'b11;
            r[7]     = mst_mpie;
            r[3]     = mst_mie;
         end
         A_MIE:       r = mie_q;
         A_MTVEC:     r = mtvec_q;
         A_MSCRATCH:  r = mscratch_q;
         A_MEPC:      r = mepc_q;
         A_MCAUSE:    r = mcause_q;
         A_MCYCLE:    r = XLEN'(mcycle_q[31:0]);
         A_MCYCLEH:   r = XLEN'(mcycle_q[63:32]);
         A_MINSTRET:  r = XLEN'(minstret_q[31:0]);
         A_MINSTRETH: r = XLEN'(minstret_q[63:32]);
         A_MHARTID:   r = HART_ID;
         default:     r = '0;
      endcase
      return r;
   endfunction

   // jtag loses to a same-cycle instruction write of the same CSR
   function automatic logic op_hit(input logic [11:0] a);
      return op_we && (op_addr == a);
   endfunction

   function automatic logic jt_hit(input logic [11:0] a);
      return jtag_we && (jtag_addr == a) && !op_hit(a);
   endfunction

   function automatic logic sw_we(input logic [11:0] a);
      return op_hit(a) || jt_hit(a);
   endfunction

   function automatic logic [XLEN-1:0] sw_val(input logic [11:0] a);
      return op_hit(a) ? op_new : jtag_wdata;
   endfunction

   function automatic logic [31:0] sw_val32(input logic [11:0] a);
      return op_hit(a) ? op_new[31:0] : jtag_wdata[31:0];
   endfunction

   function automatic logic [XLEN-1:0] mtvec_fix(input logic [XLEN-1:0] v);
      return {v[XLEN-1:2], (v[1] ? 2'b00 : v[1:0])};
   endfunction

   always_comb begin
      op_old    = csr_read(op_addr);
      op_writes = (op_type == OP_RW) || (op_type[1] && (op_wdata != '0));
      op_ill    = op_valid && (!csr_known(op_addr) || ((op_addr == A_MHARTID) && op_writes));
      op_we     = op_valid && !op_ill && op_writes;
      case (op_type)
         OP_RW:   op_new = op_wdata;
         OP_RS:   op_new = op_old | op_wdata;
         OP_RC:   op_new = op_old & ~op_wdata;
         default: op_new = op_old;
      endcase
      op_illegal = op_ill;
      op_rdata   = op_ill ? '0 : op_old;
      jtag_rdata = csr_read(jtag_addr);
   end

   always_comb begin
      tv_base = {mtvec_q[XLEN-1:2], 2'b00};
      if ((mtvec_q[1:0] == 2'b01) && trap_cause_i[XLEN-1])
         trap_vec_o = tv_base + {trap_cause_i[XLEN-3:0], 2'b00};
      else
         trap_vec_o = tv_base;
   end

   assign mepc_o = mepc_q;
   assign mie_o  = mie_q;
   assign gie_o  = mst_mie;

   // Registers that trap entry / mret can claim
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mst_mie  <= 1'b0;
         mst_mpie <= 1'b0;
         mepc_q   <= '0;
         mcause_q <= '0;
      end else if (trap_i) begin
         mepc_q   <= {trap_pc_i[XLEN-1:2], 2'b00};
         mcause_q <= trap_cause_i;
         mst_mpie <= mst_mie;
         mst_mie  <= 1'b0;
      end else begin
         if (mret_i) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end else if (op_hit(A_MSTATUS)) begin
            mst_mie  <= op_new[3];
            mst_mpie <= op_new[7];
         end else if (jt_hit(A_MSTATUS)) begin
            mst_mie  <= jtag_wdata[3];
            mst_mpie <= jtag_wdata[7];
         end
         if (sw_we(A_MEPC))   mepc_q   <= sw_val(A_MEPC) & ~XLEN'(3);
         if (sw_we(A_MCAUSE)) mcause_q <= sw_val(A_MCAUSE);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= '0;
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (sw_we(A_MIE))      mie_q      <= sw_val(A_MIE);
         if (sw_we(A_MTVEC))    mtvec_q    <= mtvec_fix(sw_val(A_MTVEC));
         if (sw_we(A_MSCRATCH)) mscratch_q <= sw_val(A_MSCRATCH);

         // A write to either half freezes the whole counter for that cycle
         if (sw_we(A_MCYCLE) || sw_we(A_MCYCLEH)) begin
            if (sw_we(A_MCYCLE))  mcycle_q[31:0]  <= sw_val32(A_MCYCLE);
            if (sw_we(A_MCYCLEH)) mcycle_q[63:32] <= sw_val32(A_MCYCLEH);
         end else begin
            mcycle_q <= mcycle_q + 64'd1;
         end

         if (sw_we(A_MINSTRET) || sw_we(A_MINSTRETH)) begin
            if (sw_we(A_MINSTRET))  minstret_q[31:0]  <= sw_val32(A_MINSTRET);
            if (sw_we(A_MINSTRETH)) minstret_q[63:32] <= sw_val32(A_MINSTRETH);
         end else if (retire_i) begin
            minstret_q <= minstret_q + 64'd1;
         end
      end
   end

endmodule
